// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
package mp_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/mp_add_seq_if.sv
// Start/done request bus of mp_add_seq; the sub signal exists only when MP_ADD_SUB_EN is defined.
interface mp_add_seq_if
  import mp_add_pkg::*;
#(
  parameter int NWORDS = 4
);

  logic                     strt;
  logic [WORD_W*NWORDS-1:0] A;
  logic [WORD_W*NWORDS-1:0] B;
  logic                     Cin;
`ifdef MP_ADD_SUB_EN
  logic                     sub;
`endif
  logic                     busy;
  logic                     done;
  logic [WORD_W*NWORDS-1:0] S;
  logic                     Cout;
  logic                     ovfl;

`ifdef MP_ADD_SUB_EN
  modport master (output strt, A, B, Cin, sub, input busy, done, S, Cout, ovfl);
  modport slave  (input strt, A, B, Cin, sub, output busy, done, S, Cout, ovfl);
`else
  modport master (output strt, A, B, Cin, input busy, done, S, Cout, ovfl);
  modport slave  (input strt, A, B, Cin, output busy, done, S, Cout, ovfl);
`endif

endinterface

// File: rtl/RCA16.sv
// 16-bit ripple-carry adder; the single arithmetic element shared across all words.
module RCA16
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              Cin,
  output logic [WORD_W-1:0] S,
  output logic              Cout
);

  // NOTE: blocking assignments here model the carry rippling bit to bit; the
  // defaults at the top of the block keep every output fully assigned (no latch).
  always_comb begin
    logic c;
    S = '0;
    c = Cin;
    for (int i = 0; i < WORD_W; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one RCA16 walked over NWORDS words, LS word first.
// Define MP_ADD_SUB_EN to add the sub port (A - B via inverted B and forced carry-in).
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mp_add_seq_if.slave  bus
);

  localparam int                IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NWORDS - 1);

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic                           carry;
  logic [NWORDS-1:0][WORD_W-1:0]  a_reg;
  logic [NWORDS-1:0][WORD_W-1:0]  b_reg;
  logic [NWORDS-1:0][WORD_W-1:0]  s_reg;
  logic                           cout_reg;
  logic                           ovfl_reg;
  logic                           busy_reg;
  logic                           done_reg;
  logic [WORD_W-1:0]              add_s;
  logic                           add_cout;
  logic                           accept;
  logic [WORD_W*NWORDS-1:0]       b_eff;
  logic                           cin_eff;

  assign accept = (state == IDLE) && bus.strt;

`ifdef MP_ADD_SUB_EN
  assign b_eff   = bus.sub ? ~bus.B : bus.B;
  assign cin_eff = bus.sub | bus.Cin;
`else
  assign b_eff   = bus.B;
  assign cin_eff = bus.Cin;
`endif

  // NOTE: the operand registers carry no reset: they are always loaded on the
  // accepting edge before RUN reads them, so a reset would only add fanout.
  // b_reg holds B as applied to the adder, so ovfl can read its MSB directly.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= bus.A;
      b_reg <= b_eff;
    end
  end

  RCA16 u_rca (
    .A    (a_reg[idx]),
    .B    (b_reg[idx]),
    .Cin  (carry),
    .S    (add_s),
    .Cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      s_reg    <= '0;
      cout_reg <= 1'b0;
      ovfl_reg <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.strt) begin
            idx      <= '0;
            carry    <= cin_eff;
            busy_reg <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          s_reg[idx] <= add_s;
          carry      <= add_cout;
          idx        <= idx + 1'b1;
          if (idx == LAST) begin
            cout_reg <= add_cout;
            ovfl_reg <= (a_reg[NWORDS-1][WORD_W-1] == b_reg[NWORDS-1][WORD_W-1]) &&
                        (add_s[WORD_W-1] != a_reg[NWORDS-1][WORD_W-1]);
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.S    = s_reg;
  assign bus.Cout = cout_reg;
  assign bus.ovfl = ovfl_reg;

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add sequencer. Performs a `16*NWORDS`-bit addition by time-multiplexing one 16-bit ripple-carry adder (`RCA16`) over `NWORDS` cycles, least-significant word first, chaining the carry through a register. It sits between a requesting controller (start/done handshake) and the shared 16-bit adder datapath. It trades latency for area in place of a wide combinational adder.

## Interface

- `NWORDS`, default 4: number of 16-bit words per operand; legal range 2..16.

- `clk`  input  1: sole clock; all state updates on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `strt`  input  1: start request; sampled only in IDLE.
- `A`  input  16*NWORDS: operand A; captured on the accepted `strt`.
- `B`  input  16*NWORDS: operand B; captured on the accepted `strt`.
- `Cin`  input  1: initial carry-in; captured on the accepted `strt`.
- `sub`  input  1: subtract select; captured on the accepted `strt`. Present only with `MP_ADD_SUB_EN`.
- `busy`  output  1: high while words are being processed.
- `done`  output  1: single-cycle pulse when the result is valid.
- `S`  output  16*NWORDS: registered sum.
- `Cout`  output  1: carry out of the most-significant word.
- `ovfl`  output  1: two's-complement signed overflow of the full-width result.

## Operation

- FSM has two states: IDLE and RUN. Word index counter `idx` is `$clog2(NWORDS)` bits wide.
- **IDLE, `strt`=1:**
  - Latch A, B and Cin into operand registers.
  - Clear `idx`; the carry register takes Cin.
  - Go to RUN.
- **IDLE, `strt`=0:** hold.
- **RUN, each cycle:**
  - Adder inputs are `A_reg[idx]`, `B_reg[idx]` and the carry register.
  - The adder sum is written to `S[16*idx +: 16]` and its Cout to the carry register.
  - `idx` increments.
- **RUN, last word (`idx == NWORDS-1`):**
  - Register `Cout` and `ovfl`.
  - `ovfl` = (A MSB == B' MSB) && (S MSB != A MSB), where B' is the operand actually applied to the adder.
  - Assert `done`; go to IDLE.
- `strt` while in RUN is ignored; operands are not re-latched.
- `S`, `Cout` and `ovfl` hold their values until the next accepted `strt`. On acceptance they are not cleared; each word of `S` updates as it is processed.
- Arithmetic is pure modulo 2^(16*NWORDS); `Cout` is the carry out of the full-width sum.

## Timing

- **Reset values:** `busy`=0, `done`=0, `S`=0, `Cout`=0, `ovfl`=0, state=IDLE, `idx`=0, carry register=0.
- **Latency:** `strt` sampled at edge E0. `busy`=1 from E0 through E`NWORDS`. `done`=1 for exactly the cycle following edge E`NWORDS`, with `busy`=0 in that cycle.
- **Back-to-back operation:** `strt` high in the `done` cycle is accepted (the FSM is in IDLE). Throughput is one operation per `NWORDS`+1 cycles.
- **Reset mid-operation:** `rst_n` low at any edge aborts immediately. All outputs and state take reset values on that edge, and no `done` is issued for the aborted operation.
- **Operand changes:** A, B and Cin changing during RUN have no effect.

## Configuration

- Macro: `MP_ADD_SUB_EN`.
- **Defined:**
  - The `sub` port exists.
  - When `sub`=1 is captured, the B words are bitwise inverted into the adder and the carry register is initialised to 1, ignoring Cin. Result is A − B.
  - `Cout`=1 means no borrow. `ovfl` uses the inverted B MSB.
- **Undefined:**
  - No `sub` port.
  - Add only.

## Structure

- Package `mp_add_pkg`:
  - `typedef enum logic {IDLE, RUN} state_t`
  - `localparam WORD_W = 16`
- Sub-module: one `RCA16` instance (ports A, B, Cin, S, Cout) as the only arithmetic element. No `+` operator on operand data in `mp_add_seq` itself.
- The operand registers are indexed word slices. The result register is written one word per cycle.

## Test plan

All cases use NWORDS=4.

1. **Carry across words.** A=0x0000_0000_0000_FFFF, B=0x1, Cin=0 → S=0x0000_0000_0001_0000, Cout=0, ovfl=0. `done` appears exactly 4 cycles after the `strt` edge, for 1 cycle.
2. **Full carry chain.** A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 → S=0, Cout=1, ovfl=0.
3. **Signed overflow.** A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, Cin=0 → S=0x8000_0000_0000_0000, ovfl=1, Cout=0.
4. **Start while busy.** `strt` held high with different operands 2 cycles after the first `strt` → the result matches the first operands only. Exactly one `done`, followed by a second `done` 5 cycles later.
5. **Reset mid-operation.** `rst_n`=0 for one edge in the 2nd RUN cycle → `busy`, `done`, `S`, `Cout`, `ovfl` all 0 after that edge, no `done`. A following `strt` with A=3, B=4 gives S=7.
6. **Subtract and random check.** With `MP_ADD_SUB_EN`: `sub`=1, A=5, B=7 → S=0xFFFF_FFFF_FFFF_FFFE, Cout=0. Then 1000 random A/B/Cin vectors are self-checked against {Cout,S} = A+B+Cin, and the bench prints pass/fail.
